// File: rtl/branch_predictor.sv
// Direct-mapped bimodal branch predictor: combinational IF lookup, EX resolution
// (mispredict/redirect), table training and saturating performance counters.
module branch_predictor #(
   parameter int XLEN    = 64,
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8,
   parameter int MODE    = 1,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  if_pc,
   output logic             pred_taken,
   output logic [XLEN-1:0]  pred_target,
   input  logic             ex_valid,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic             ex_taken,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_pred_target,
   output logic             mispredict,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mp_count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic [ENTRIES-1:0] valid_q;
   logic [1:0]         ctr_q [ENTRIES];
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [XLEN-1:0]    tgt_q [ENTRIES];

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             if_hit, ex_hit;
   logic [XLEN-1:0]  if_seq, ex_seq, ex_correct;
   logic [1:0]       ctr_d;
   logic [CNT_W-1:0] br_q, br_d, mp_q, mp_d;

   assign if_idx = if_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign if_tag = if_pc[IDX_W+2+TAG_W-1:IDX_W+2];
   assign ex_tag = ex_pc[IDX_W+2+TAG_W-1:IDX_W+2];
   assign if_seq = if_pc + PC_STEP;
   assign ex_seq = ex_pc + PC_STEP;
   assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

   always_comb begin
      pred_taken  = (MODE != 0) && if_hit && ctr_q[if_idx][1];
      pred_target = pred_taken ? tgt_q[if_idx] : if_seq;
   end

   // The carried prediction is wrong if either the direction or the next PC differs.
   always_comb begin
      ex_correct  = ex_taken ? ex_target : ex_seq;
      mispredict  = 1'b0;
      redirect_pc = ex_seq;
      if (ex_valid) begin
         redirect_pc = ex_correct;
         mispredict  = (ex_taken != ex_pred_taken) || (ex_pred_target != ex_correct);
      end
   end

   always_comb begin
      ctr_d = ctr_q[ex_idx];
      if (ex_taken) begin
         if (ctr_q[ex_idx] != 2'b11) ctr_d = ctr_q[ex_idx] + 2'd1;
      end else begin
         if (ctr_q[ex_idx] != 2'b00) ctr_d = ctr_q[ex_idx] - 2'd1;
      end
   end

   always_comb begin
      br_d = br_q;
      mp_d = mp_q;
      if (ex_valid && (br_q != '1)) br_d = br_q + CNT_W'(1);
      if (mispredict && (mp_q != '1)) mp_d = mp_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
         br_q <= '0;
         mp_q <= '0;
      end else begin
         br_q <= br_d;
         mp_q <= mp_d;
         if (ex_valid) begin
            if (ex_hit) begin
               ctr_q[ex_idx] <= ctr_d;
            end else if (ex_taken) begin
               valid_q[ex_idx] <= 1'b1;
               ctr_q[ex_idx]   <= 2'b10;
            end
         end
      end
   end

   // Tags and targets need no reset; they are only read behind a valid bit.
   always_ff @(posedge clk) begin
      if (ex_valid && ex_taken) begin
         tgt_q[ex_idx] <= ex_target;
         tag_q[ex_idx] <= ex_tag;
      end
   end

   assign br_count = br_q;
   assign mp_count = mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a bimodal instance, a static not-taken
// instance and a 4-bit-counter instance share one set of inputs.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [63:0] ifPc = 64'h0;
   logic        exValid = 1'b0;
   logic [63:0] exPc = 64'h0;
   logic        exTaken = 1'b0;
   logic [63:0] exTarget = 64'h0;
   logic        exPredTaken = 1'b0;
   logic [63:0] exPredTarget = 64'h0;

   logic        predTaken, predTaken0, predTaken4;
   logic [63:0] predTarget, predTarget0, predTarget4;
   logic        mispredict, mispredict0, mispredict4;
   logic [63:0] redirectPc, redirectPc0, redirectPc4;
   logic [31:0] brCount, mpCount, brCount0, mpCount0;
   logic [3:0]  brCount4, mpCount4;

   int testsRun = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_predictor #(.ENTRIES(16), .MODE(1)) dutMain (
      .clk(clk), .rst_n(rst_n), .if_pc(ifPc), .pred_taken(predTaken), .pred_target(predTarget),
      .ex_valid(exValid), .ex_pc(exPc), .ex_taken(exTaken), .ex_target(exTarget),
      .ex_pred_taken(exPredTaken), .ex_pred_target(exPredTarget), .mispredict(mispredict),
      .redirect_pc(redirectPc), .br_count(brCount), .mp_count(mpCount));

   branch_predictor #(.ENTRIES(16), .MODE(0)) dutStatic (
      .clk(clk), .rst_n(rst_n), .if_pc(ifPc), .pred_taken(predTaken0), .pred_target(predTarget0),
      .ex_valid(exValid), .ex_pc(exPc), .ex_taken(exTaken), .ex_target(exTarget),
      .ex_pred_taken(exPredTaken), .ex_pred_target(exPredTarget), .mispredict(mispredict0),
      .redirect_pc(redirectPc0), .br_count(brCount0), .mp_count(mpCount0));

   branch_predictor #(.ENTRIES(16), .MODE(1), .CNT_W(4)) dutSmall (
      .clk(clk), .rst_n(rst_n), .if_pc(ifPc), .pred_taken(predTaken4), .pred_target(predTarget4),
      .ex_valid(exValid), .ex_pc(exPc), .ex_taken(exTaken), .ex_target(exTarget),
      .ex_pred_taken(exPredTaken), .ex_pred_target(exPredTarget), .mispredict(mispredict4),
      .redirect_pc(redirectPc4), .br_count(brCount4), .mp_count(mpCount4));

   task automatic applyStimulus(input logic t, input logic [63:0] pc, input logic [63:0] tgt,
                                input logic pt, input logic [63:0] ptgt);
      exValid = 1'b1; exPc = pc; exTaken = t; exTarget = tgt;
      exPredTaken = pt; exPredTarget = ptgt;
      #1;
   endtask

   task automatic commit();
      @(posedge clk); #1;
      exValid = 1'b0;
      #1;
   endtask

   task automatic lookup(input logic [63:0] pc);
      ifPc = pc;
      #1;
   endtask

   task automatic doReset();
      @(posedge clk); #2;
      rst_n = 1'b0; exValid = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2;
      rst_n = 1'b0; exValid = 1'b0; ifPc = 64'h100;
      #1;
      testsRun++;
      if (predTaken !== 1'b0) begin failures++; $display("[TB] FAIL reset_pred_taken got %0b exp 0", predTaken); end
      testsRun++;
      if (predTarget !== 64'h104) begin failures++; $display("[TB] FAIL reset_pred_target got %h exp 104", predTarget); end
      testsRun++;
      if (brCount !== 32'd0 || mpCount !== 32'd0) begin
         failures++; $display("[TB] FAIL reset_counters got br=%0d mp=%0d exp 0/0", brCount, mpCount);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_allocate();
      lookup(64'h100);
      applyStimulus(1'b1, 64'h100, 64'h40, 1'b0, 64'h104);
      testsRun++;
      if (mispredict !== 1'b1 || redirectPc !== 64'h40) begin
         failures++; $display("[TB] FAIL alloc_resolve got mp=%0b rd=%h exp 1/40", mispredict, redirectPc);
      end
      testsRun++;
      if (predTaken !== 1'b0) begin failures++; $display("[TB] FAIL alloc_same_cycle got %0b exp 0", predTaken); end
      commit();
      lookup(64'h100);
      testsRun++;
      if (predTaken !== 1'b1 || predTarget !== 64'h40) begin
         failures++; $display("[TB] FAIL alloc_predict got %0b/%h exp 1/40", predTaken, predTarget);
      end
   endtask

   task automatic test_hysteresis();
      applyStimulus(1'b0, 64'h100, 64'h40, 1'b1, 64'h40);
      testsRun++;
      if (mispredict !== 1'b1 || redirectPc !== 64'h104) begin
         failures++; $display("[TB] FAIL hyst_nt_resolve got mp=%0b rd=%h exp 1/104", mispredict, redirectPc);
      end
      commit();
      lookup(64'h100);
      testsRun++;
      if (predTaken !== 1'b0 || predTarget !== 64'h104) begin
         failures++; $display("[TB] FAIL hyst_wn got %0b/%h exp 0/104", predTaken, predTarget);
      end
      applyStimulus(1'b1, 64'h100, 64'h40, 1'b1, 64'h40);
      testsRun++;
      if (mispredict !== 1'b0) begin failures++; $display("[TB] FAIL hyst_correct got %0b exp 0", mispredict); end
      commit();
      applyStimulus(1'b1, 64'h100, 64'h40, 1'b1, 64'h40);
      commit();
      applyStimulus(1'b0, 64'h100, 64'h40, 1'b1, 64'h40);
      commit();
      lookup(64'h100);
      testsRun++;
      if (predTaken !== 1'b1 || predTarget !== 64'h40) begin
         failures++; $display("[TB] FAIL hyst_st_to_wt got %0b/%h exp 1/40", predTaken, predTarget);
      end
   endtask

   task automatic test_alias();
      applyStimulus(1'b1, 64'h140, 64'h80, 1'b0, 64'h144);
      commit();
      lookup(64'h100);
      testsRun++;
      if (predTaken !== 1'b0 || predTarget !== 64'h104) begin
         failures++; $display("[TB] FAIL alias_old_miss got %0b/%h exp 0/104", predTaken, predTarget);
      end
      lookup(64'h140);
      testsRun++;
      if (predTaken !== 1'b1 || predTarget !== 64'h80) begin
         failures++; $display("[TB] FAIL alias_new_hit got %0b/%h exp 1/80", predTaken, predTarget);
      end
   endtask

   task automatic test_target_change();
      applyStimulus(1'b1, 64'h100, 64'h40, 1'b0, 64'h104);
      commit();
      applyStimulus(1'b1, 64'h100, 64'h60, 1'b1, 64'h40);
      testsRun++;
      if (mispredict !== 1'b1 || redirectPc !== 64'h60) begin
         failures++; $display("[TB] FAIL tgt_change_resolve got mp=%0b rd=%h exp 1/60", mispredict, redirectPc);
      end
      commit();
      lookup(64'h100);
      testsRun++;
      if (predTaken !== 1'b1 || predTarget !== 64'h60) begin
         failures++; $display("[TB] FAIL tgt_change_table got %0b/%h exp 1/60", predTaken, predTarget);
      end
      applyStimulus(1'b1, 64'h100, 64'h60, 1'b1, 64'h60);
      testsRun++;
      if (mispredict !== 1'b0) begin failures++; $display("[TB] FAIL tgt_correct got %0b exp 0", mispredict); end
      commit();
      testsRun++;
      if (brCount !== 32'd9 || mpCount !== 32'd6) begin
         failures++; $display("[TB] FAIL perf_counts got br=%0d mp=%0d exp 9/6", brCount, mpCount);
      end
   endtask

   task automatic test_idle_and_wrap();
      exValid = 1'b0; exPc = 64'hFFFF_FFFF_FFFF_FFFC; exTaken = 1'b1; exTarget = 64'h40;
      exPredTaken = 1'b0; exPredTarget = 64'h0;
      lookup(64'hFFFF_FFFF_FFFF_FFFC);
      testsRun++;
      if (mispredict !== 1'b0 || redirectPc !== 64'h0) begin
         failures++; $display("[TB] FAIL idle_resolve got mp=%0b rd=%h exp 0/0", mispredict, redirectPc);
      end
      testsRun++;
      if (predTaken !== 1'b0 || predTarget !== 64'h0) begin
         failures++; $display("[TB] FAIL wrap_lookup got %0b/%h exp 0/0", predTaken, predTarget);
      end
   endtask

   task automatic test_reset_mid_update();
      doReset();
      applyStimulus(1'b1, 64'h200, 64'h80, 1'b0, 64'h204);
      #2;
      rst_n = 1'b0;
      @(posedge clk); #1;
      exValid = 1'b0;
      rst_n = 1'b1;
      lookup(64'h200);
      testsRun++;
      if (predTaken !== 1'b0 || brCount !== 32'd0) begin
         failures++; $display("[TB] FAIL reset_mid_update got pt=%0b br=%0d exp 0/0", predTaken, brCount);
      end
   endtask

   task automatic test_mode0();
      doReset();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 64'h100, 64'h40, 1'b0, 64'h104);
         testsRun++;
         if (mispredict0 !== 1'b1) begin failures++; $display("[TB] FAIL mode0_mp[%0d] got %0b exp 1", i, mispredict0); end
         commit();
      end
      lookup(64'h100);
      testsRun++;
      if (predTaken0 !== 1'b0 || predTarget0 !== 64'h104) begin
         failures++; $display("[TB] FAIL mode0_predict got %0b/%h exp 0/104", predTaken0, predTarget0);
      end
      testsRun++;
      if (predTaken !== 1'b1) begin failures++; $display("[TB] FAIL mode1_trained got %0b exp 1", predTaken); end
   endtask

   task automatic test_saturation();
      doReset();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 64'h300 + 64'(i * 4), 64'h80, 1'b0, 64'h0);
         commit();
      end
      testsRun++;
      if (brCount4 !== 4'd15 || mpCount4 !== 4'd15) begin
         failures++; $display("[TB] FAIL cnt4_saturate got br=%0d mp=%0d exp 15/15", brCount4, mpCount4);
      end
      testsRun++;
      if (brCount !== 32'd20 || mpCount !== 32'd20) begin
         failures++; $display("[TB] FAIL cnt32_count got br=%0d mp=%0d exp 20/20", brCount, mpCount);
      end
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_hysteresis();
      test_alias();
      test_target_change();
      test_idle_and_wrap();
      test_reset_mid_update();
      test_mode0();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the pipelined RV64 core. It replaces always-not-taken fetch plus flush-on-every-taken-branch. The IF stage looks up the fetch PC combinationally. The EX stage reports each resolved branch back, which trains a direct-mapped table of 2-bit saturating counters and branch targets. The block produces the mispredict/flush and redirect PC, and keeps saturating performance counters.

## Interface
Parameters:
- XLEN, 64, PC and target width.
- ENTRIES, 16, table depth; power of two, 2..1024. IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry; tag = pc[IDX_W+2+TAG_W-1 : IDX_W+2].
- MODE, 1, 0 = static not-taken (table still trains, predictions forced not-taken), 1 = bimodal.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  XLEN  fetch PC for lookup.
- pred_taken  out  1  prediction for if_pc.
- pred_target  out  XLEN  next fetch PC predicted for if_pc.
- ex_valid  in  1  a branch resolves in EX this cycle.
- ex_pc  in  XLEN  PC of the resolving branch.
- ex_taken  in  1  actual outcome.
- ex_target  in  XLEN  actual taken target.
- ex_pred_taken  in  1  prediction carried down the pipe with this branch.
- ex_pred_target  in  XLEN  predicted next PC carried down the pipe.
- mispredict  out  1  flush IF/ID and ID/EX, then redirect.
- redirect_pc  out  XLEN  correct next PC.
- br_count  out  CNT_W  branches resolved.
- mp_count  out  CNT_W  mispredictions.

## Operation
- Indexing: idx = pc[IDX_W+1:2]. Each entry holds valid, tag[TAG_W], target[XLEN], ctr[2].
- Counter encoding: 00 strongly-not-taken (SN), 01 weakly-not-taken (WN), 10 weakly-taken (WT), 11 strongly-taken (ST).
- Lookup (combinational):
  - hit = valid[idx] & (tag[idx] == if_pc tag field).
  - MODE=1: pred_taken = hit & ctr[idx][1].
  - MODE=0: pred_taken = 0.
  - pred_target = pred_taken ? target[idx] : if_pc + 4.
- Resolution (combinational, gated by ex_valid):
  - mispredict = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_target != ex_target) | (!ex_taken & ex_pred_target != ex_pc+4)).
  - redirect_pc = ex_taken ? ex_target : ex_pc + 4.
  - Outside ex_valid: mispredict = 0 and redirect_pc = ex_pc + 4.
- Update, on a clock edge with ex_valid = 1:
  - Entry hit, taken: ctr increments, saturating at 11; target <= ex_target.
  - Entry hit, not taken: ctr decrements, saturating at 00; target unchanged.
  - Entry miss, taken: allocate, overwriting any previous occupant. valid <= 1, tag, target <= ex_target, ctr <= 10 (WT).
  - Entry miss, not taken: no change.
- Performance counters: br_count += 1 on every ex_valid; mp_count += 1 on every mispredict. Both saturate at all-ones and do not wrap.
- PC arithmetic: +4 is modulo 2^XLEN, so 0xFFFF_FFFF_FFFF_FFFC + 4 = 0.

## Timing
- Lookup and resolution outputs are combinational, with zero latency.
- Table and counter updates take effect at the rising edge of ex_valid's cycle and are visible to lookup the next cycle.
- Same-cycle lookup and update of the same idx: lookup returns pre-update contents.
- Reset, asynchronous on rst_n low:
  - All valid bits <= 0, all ctr <= 01, br_count = mp_count = 0.
  - Targets and tags are don't-care.
  - pred_taken reads 0 immediately; pred_target = if_pc + 4.
- Reset asserted mid-update: the update is lost. The table is clean on the first edge after rst_n rises.
- No stall input: the block is stateless with respect to pipeline stalls. The pipe holds ex_valid low during bubbles and flushed slots.

## Test plan
- Reset: ENTRIES=16. Pulse rst_n low.
  - if_pc=0x100 -> pred_taken=0, pred_target=0x104, br_count=mp_count=0.
- Allocate and predict, MODE=1:
  - Resolve ex_pc=0x100, taken, target 0x40, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x40.
  - Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x40.
- Hysteresis, starting from the entry above at WT:
  - One not-taken resolve -> WN; lookup gives pred_taken=0.
  - Two taken resolves -> ST.
  - One not-taken resolve -> WT; still predicts taken.
- Aliasing: ex_pc=0x140 (same idx as 0x100, different tag), taken, target 0x80.
  - Lookup 0x100 -> miss, pred_taken=0.
  - Lookup 0x140 -> target 0x80.
- Target change on hit: entry predicts 0x40; branch taken to 0x60 with ex_pred_target=0x40 -> mispredict=1, redirect_pc=0x60; the table then holds 0x60.
- Mode and counter saturation:
  - MODE=0: any taken resolve -> mispredict=1; pred_taken stays 0 after training.
  - CNT_W=4: 20 mispredicting resolves -> br_count=mp_count=15.
